cfr_shadow_bank: RTL and testbench

CFR_SHADOW_BANK -- requirements
Module: cfr_shadow_bank

---
 rtl/cfr_shadow_bank_pkg.sv | 37 +++
 rtl/cfr_shadow_bank_commit_fsm.sv | 76 +++++++
 rtl/cfr_shadow_bank.sv | 179 +++++++++++++++++
 tb/tb_cfr_shadow_bank.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfr_shadow_bank_pkg.sv
// -----------------------------------------------------------------------------
// aimc_lib -- shared definitions for the CFR shadow/active configuration bank.
//   * cfr_commit_state_e : per-channel commit FSM states
//   * CFR_*_BASE         : address-map base constants (shadow/active/status)
//   * cfr_word_init(w)   : reset value of word w (shadow and every active copy)
// cfr_word_init returns CFR_INIT_MAX_WIDTH bits; users keep the low DATA_WIDTH.
// Every 32-bit lane l of word w holds 0xCF00_<w[7:0]><l[7:0]>, so each word
// and each lane of the reset image is distinguishable.
// -----------------------------------------------------------------------------
package aimc_lib;

   typedef enum logic [1:0] {
      CFR_ST_IDLE = 2'b00,
      CFR_ST_PEND = 2'b01,
      CFR_ST_COPY = 2'b10
   } cfr_commit_state_e;

   localparam logic [31:0] CFR_SHADOW_BASE = 32'h0000_0000;
   localparam logic [31:0] CFR_ACTIVE_BASE = 32'h0000_0100;
   localparam logic [31:0] CFR_STATUS_BASE = 32'h0000_0200;

   localparam int CFR_INIT_MAX_WIDTH = 2048;

   function automatic logic [CFR_INIT_MAX_WIDTH-1:0] cfr_word_init(input int unsigned w);
      logic [CFR_INIT_MAX_WIDTH-1:0] word;
      logic [7:0] w8;
      logic [7:0] l8;
      word = '0;
      w8   = w[7:0];
      for (int l = 0; l < CFR_INIT_MAX_WIDTH / 32; l++) begin
         l8 = l[7:0];
         word[l*32 +: 32] = {8'hCF, 8'h00, w8, l8};
      end
      return word;
   endfunction

endpackage

// File: rtl/cfr_shadow_bank_commit_fsm.sv
// -----------------------------------------------------------------------------
// cfr_commit_fsm -- one channel's commit sequencer.
//   IDLE --req--> PEND --ch_idle--> COPY --(1 cycle)--> IDLE, or PEND if a new
//   request arrived during COPY. Requests arriving in PEND merge.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   req       : commit request (pin and status-register requests already OR-ed)
//   ch_idle   : channel quiescent; allows PEND->COPY
//   copy      : combinational strobe, high on the cycle whose edge does the copy
//   pend      : registered, high while in PEND
//   done      : registered, high while in COPY (one-cycle pulse)
// -----------------------------------------------------------------------------
module cfr_commit_fsm
   import aimc_lib::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  logic ch_idle,
   output logic copy,
   output logic pend,
   output logic done
);

   cfr_commit_state_e state_r;
   cfr_commit_state_e state_nxt_s;
   logic              copy_s;
   logic              pend_r;
   logic              done_r;

   // Next-state decode and copy strobe.
   always_comb begin
      state_nxt_s = state_r;
      copy_s      = 1'b0;
      case (state_r)
         CFR_ST_IDLE: begin
            if (req) state_nxt_s = CFR_ST_PEND;
            else     state_nxt_s = CFR_ST_IDLE;
         end
         CFR_ST_PEND: begin
            // a request seen here is merged into the one already pending
            if (ch_idle) begin
               state_nxt_s = CFR_ST_COPY;
               copy_s      = 1'b1;
            end else begin
               state_nxt_s = CFR_ST_PEND;
            end
         end
         CFR_ST_COPY: begin
            if (req) state_nxt_s = CFR_ST_PEND;
            else     state_nxt_s = CFR_ST_IDLE;
         end
         default: begin
            state_nxt_s = CFR_ST_IDLE;
         end
      endcase
   end

   // State register; pend/done are registered decodes of the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= CFR_ST_IDLE;
         pend_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         pend_r  <= (state_nxt_s == CFR_ST_PEND);
         done_r  <= (state_nxt_s == CFR_ST_COPY);
      end
   end

   assign copy = copy_s;
   assign pend = pend_r;
   assign done = done_r;

endmodule

// File: rtl/cfr_shadow_bank.sv
// -----------------------------------------------------------------------------
// cfr_shadow_bank -- CPU-writable shadow config words, atomically copied into
// per-channel active words when each channel is idle.
// Address map (word addresses):
//   0x000 + w               shadow word w (R/W, byte-masked writes)
//   0x100 + c*NUM_WORDS + w active word w of channel c (read-only)
//   0x200                   status: read = pend bits, write din[c]&mask[0] = commit c
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cfr_we/re/addr/mask/din       register access strobes, address, byte enables, data
//   cfr_dout, cfr_rvalid          read data (latency 1) and its valid pulse
//   cfr_err                       one-cycle pulse one cycle after an illegal access
//   commit_req, ch_idle           per-channel commit request and quiescent flag
//   commit_pend, commit_done      per-channel commit waiting / copy-complete pulse
//   cfr_active_p                  packed active config, channel-major then word
// -----------------------------------------------------------------------------
module cfr_shadow_bank
   import aimc_lib::*;
#(
   parameter int DATA_WIDTH     = 256,
   parameter int CFR_ADDR_WIDTH = 12,
   parameter int NUM_WORDS      = 8,
   parameter int NUM_CH         = 2
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   cfr_we,
   input  logic                                   cfr_re,
   input  logic [CFR_ADDR_WIDTH-1:0]              cfr_addr,
   input  logic [DATA_WIDTH/8-1:0]                cfr_mask,
   input  logic [DATA_WIDTH-1:0]                  cfr_din,
   output logic [DATA_WIDTH-1:0]                  cfr_dout,
   output logic                                   cfr_rvalid,
   output logic                                   cfr_err,
   input  logic [NUM_CH-1:0]                      commit_req,
   input  logic [NUM_CH-1:0]                      ch_idle,
   output logic [NUM_CH-1:0]                      commit_pend,
   output logic [NUM_CH-1:0]                      commit_done,
   output logic [NUM_CH*NUM_WORDS*DATA_WIDTH-1:0] cfr_active_p
);

   localparam int          MASK_W = DATA_WIDTH / 8;
   localparam int          WI     = $clog2(NUM_WORDS);
   localparam int          CI     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [31:0] NW32   = 32'(NUM_WORDS);
   localparam logic [31:0] NACT32 = 32'(NUM_CH * NUM_WORDS);

   logic [DATA_WIDTH-1:0] shadow_r [NUM_WORDS];
   logic [DATA_WIDTH-1:0] active_r [NUM_CH][NUM_WORDS];

   logic [31:0]           addr_ext_s;
   logic                  is_shadow_s;
   logic                  is_active_s;
   logic                  is_status_s;
   logic [WI-1:0]         sh_idx_s;
   logic [CI-1:0]         act_ch_s;
   logic [WI-1:0]         act_w_s;
   logic [DATA_WIDTH-1:0] rd_data_s;
   logic                  illegal_s;
   logic [NUM_CH-1:0]     status_req_s;
   logic [NUM_CH-1:0]     commit_req_s;
   logic [NUM_CH-1:0]     copy_s;
   logic [DATA_WIDTH-1:0] dout_r;
   logic                  rvalid_r;
   logic                  err_r;

   // Address decode; offsets use unsigned wrap so below-base addresses miss.
   always_comb begin
      addr_ext_s  = 32'(cfr_addr);
      is_shadow_s = ((addr_ext_s - CFR_SHADOW_BASE) < NW32);
      is_active_s = ((addr_ext_s - CFR_ACTIVE_BASE) < NACT32);
      is_status_s = (addr_ext_s == CFR_STATUS_BASE);
      sh_idx_s    = WI'(addr_ext_s - CFR_SHADOW_BASE);
      act_ch_s    = CI'((addr_ext_s - CFR_ACTIVE_BASE) / NW32);
      act_w_s     = WI'((addr_ext_s - CFR_ACTIVE_BASE) % NW32);
   end

   // Read mux (pre-write contents) and illegal-access detection.
   always_comb begin
      rd_data_s = '0;
      if (is_shadow_s) begin
         rd_data_s = shadow_r[sh_idx_s];
      end else if (is_active_s) begin
         rd_data_s = active_r[act_ch_s][act_w_s];
      end else if (is_status_s) begin
         rd_data_s[NUM_CH-1:0] = commit_pend;
      end else begin
         rd_data_s = '0;
      end
      illegal_s = (cfr_we && !(is_shadow_s || is_status_s)) ||
                  (cfr_re && !(is_shadow_s || is_active_s || is_status_s));
   end

   // Status-register commits OR-ed with the pins so a coincident pair is one request.
   always_comb begin
      status_req_s = '0;
      if (cfr_we && is_status_s && cfr_mask[0]) begin
         status_req_s = cfr_din[NUM_CH-1:0];
      end else begin
         status_req_s = '0;
      end
      commit_req_s = commit_req | status_req_s;
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      cfr_commit_fsm u_fsm (
         .clk     (clk),
         .rst     (rst),
         .req     (commit_req_s[c]),
         .ch_idle (ch_idle[c]),
         .copy    (copy_s[c]),
         .pend    (commit_pend[c]),
         .done    (commit_done[c])
      );
   end

   // Shadow words: reset image, then byte-masked CPU writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int w = 0; w < NUM_WORDS; w++) begin
            shadow_r[w] <= DATA_WIDTH'(cfr_word_init(w));
         end
      end else if (cfr_we && is_shadow_s) begin
         for (int b = 0; b < MASK_W; b++) begin
            if (cfr_mask[b]) begin
               shadow_r[sh_idx_s][b*8 +: 8] <= cfr_din[b*8 +: 8];
            end
         end
      end
   end

   // Active words: change only by a whole-bank copy of the pre-edge shadow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
               active_r[c][w] <= DATA_WIDTH'(cfr_word_init(w));
            end
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (copy_s[c]) begin
               for (int w = 0; w < NUM_WORDS; w++) begin
                  active_r[c][w] <= shadow_r[w];
               end
            end
         end
      end
   end

   // Read data / valid / error response registers; dout holds between reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_r   <= '0;
         rvalid_r <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         rvalid_r <= cfr_re;
         err_r    <= illegal_s;
         if (cfr_re) dout_r <= rd_data_s;
         else        dout_r <= dout_r;
      end
   end

   // Flatten the active words onto the packed output bus.
   always_comb begin
      cfr_active_p = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         for (int w = 0; w < NUM_WORDS; w++) begin
            cfr_active_p[(c*NUM_WORDS + w)*DATA_WIDTH +: DATA_WIDTH] = active_r[c][w];
         end
      end
   end

   assign cfr_dout   = dout_r;
   assign cfr_rvalid = rvalid_r;
   assign cfr_err    = err_r;

endmodule

// File: tb/tb_cfr_shadow_bank.sv
// -----------------------------------------------------------------------------
// tb_cfr_shadow_bank -- directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level model (shadow/active arrays, one
// "waiting"/"copying" flag pair per channel).
// -----------------------------------------------------------------------------
module tb_cfr_shadow_bank;

   localparam int DW = 256;
   localparam int AW = 12;
   localparam int NW = 8;
   localparam int NC = 2;
   localparam int MW = DW / 8;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               cfr_we = 1'b0;
   logic               cfr_re = 1'b0;
   logic [AW-1:0]      cfr_addr = '0;
   logic [MW-1:0]      cfr_mask = '0;
   logic [DW-1:0]      cfr_din = '0;
   logic [DW-1:0]      cfr_dout;
   logic               cfr_rvalid;
   logic               cfr_err;
   logic [NC-1:0]      commit_req = '0;
   logic [NC-1:0]      ch_idle = '0;
   logic [NC-1:0]      commit_pend;
   logic [NC-1:0]      commit_done;
   logic [NC*NW*DW-1:0] cfr_active_p;

   always #5 clk = ~clk;

   cfr_shadow_bank #(
      .DATA_WIDTH     (DW),
      .CFR_ADDR_WIDTH (AW),
      .NUM_WORDS      (NW),
      .NUM_CH         (NC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cfr_we       (cfr_we),
      .cfr_re       (cfr_re),
      .cfr_addr     (cfr_addr),
      .cfr_mask     (cfr_mask),
      .cfr_din      (cfr_din),
      .cfr_dout     (cfr_dout),
      .cfr_rvalid   (cfr_rvalid),
      .cfr_err      (cfr_err),
      .commit_req   (commit_req),
      .ch_idle      (ch_idle),
      .commit_pend  (commit_pend),
      .commit_done  (commit_done),
      .cfr_active_p (cfr_active_p)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [DW-1:0] m_sh  [NW];
   logic [DW-1:0] m_act [NC][NW];
   bit            m_waiting [NC];
   bit            m_copying [NC];
   logic [DW-1:0] m_dout;
   logic          m_rvalid;
   logic          m_err;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] init_word(input int w);
      logic [DW-1:0] v;
      for (int l = 0; l < DW / 32; l++) begin
         v[l*32 +: 32] = 32'hCF00_0000 + 32'(w) * 32'd256 + 32'(l);
      end
      return v;
   endfunction

   function automatic logic [DW-1:0] act_word(input int c, input int w);
      return cfr_active_p[(c*NW + w)*DW +: DW];
   endfunction

   task automatic model_reset();
      for (int w = 0; w < NW; w++) begin
         m_sh[w] = init_word(w);
         for (int c = 0; c < NC; c++) m_act[c][w] = init_word(w);
      end
      for (int c = 0; c < NC; c++) begin
         m_waiting[c] = 1'b0;
         m_copying[c] = 1'b0;
      end
      m_dout   = '0;
      m_rvalid = 1'b0;
      m_err    = 1'b0;
   endtask

   // Advance the model by one clock using the inputs presented this cycle.
   task automatic model_update();
      int            ai;
      bit            sh, act, st;
      logic [DW-1:0] rv;
      bit            req;
      ai  = int'(cfr_addr);
      sh  = (ai < NW);
      act = (ai >= 256) && (ai < 256 + NC*NW);
      st  = (ai == 512);
      rv  = '0;
      if (sh)       rv = m_sh[ai];
      else if (act) rv = m_act[(ai-256)/NW][(ai-256)%NW];
      else if (st) begin
         for (int c = 0; c < NC; c++) rv[c] = m_waiting[c];
      end
      m_err    = (cfr_we && !(sh || st)) || (cfr_re && !(sh || act || st));
      m_rvalid = cfr_re;
      if (cfr_re) m_dout = rv;
      for (int c = 0; c < NC; c++) begin
         req = commit_req[c] || (cfr_we && st && cfr_mask[0] && cfr_din[c]);
         if (m_waiting[c]) begin
            if (ch_idle[c]) begin
               for (int w = 0; w < NW; w++) m_act[c][w] = m_sh[w];
               m_waiting[c] = 1'b0;
               m_copying[c] = 1'b1;
            end
         end else begin
            m_copying[c] = 1'b0;
            m_waiting[c] = req;
         end
      end
      if (cfr_we && sh) begin
         for (int b = 0; b < MW; b++) begin
            if (cfr_mask[b]) m_sh[ai][b*8 +: 8] = cfr_din[b*8 +: 8];
         end
      end
   endtask

   task automatic compare_all();
      check("rvalid", DW'(cfr_rvalid), DW'(m_rvalid));
      check("dout", cfr_dout, m_dout);
      check("err", DW'(cfr_err), DW'(m_err));
      for (int c = 0; c < NC; c++) begin
         check($sformatf("pend%0d", c), DW'(commit_pend[c]), DW'(m_waiting[c]));
         check($sformatf("done%0d", c), DW'(commit_done[c]), DW'(m_copying[c]));
         for (int w = 0; w < NW; w++) begin
            check($sformatf("active_c%0d_w%0d", c, w), act_word(c, w), m_act[c][w]);
         end
      end
   endtask

   task automatic step(input logic we, input logic re, input logic [AW-1:0] a,
                       input logic [MW-1:0] m, input logic [DW-1:0] d,
                       input logic [NC-1:0] cr, input logic [NC-1:0] ci);
      @(negedge clk);
      cfr_we = we; cfr_re = re; cfr_addr = a; cfr_mask = m; cfr_din = d;
      commit_req = cr; ch_idle = ci;
      @(posedge clk);
      model_update();
      #1;
      compare_all();
   endtask

   task automatic idle(input logic [NC-1:0] ci);
      step(1'b0, 1'b0, '0, '0, '0, '0, ci);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      cfr_we = 1'b0; cfr_re = 1'b0; commit_req = '0;
      model_reset();
      #1;
      compare_all();
      repeat (2) @(negedge clk);
      compare_all();
      rst = 1'b0;
   endtask

   logic [DW-1:0] tmp;
   logic [DW-1:0] rnd;
   logic [AW-1:0] ra;

   initial begin
      model_reset();
      apply_reset();

      // write all-ones mask A5 pattern to shadow 0, read back, active unchanged
      step(1'b1, 1'b0, 12'h000, {MW{1'b1}}, {MW{8'hA5}}, 2'b00, 2'b00);
      step(1'b0, 1'b1, 12'h000, '0, '0, 2'b00, 2'b00);
      check("a5_rvalid", DW'(cfr_rvalid), DW'(1'b1));
      check("a5_dout", cfr_dout, {MW{8'hA5}});
      step(1'b0, 1'b1, 12'h100, '0, '0, 2'b00, 2'b00);
      check("active0_init", cfr_dout, init_word(0));

      // partial mask: only bytes 0..3 of shadow word 1 change
      step(1'b1, 1'b0, 12'h001, 32'h0000_000F, {MW{8'hFF}}, 2'b00, 2'b00);
      step(1'b0, 1'b1, 12'h001, '0, '0, 2'b00, 2'b00);
      tmp = init_word(1);
      tmp[31:0] = 32'hFFFF_FFFF;
      check("mask_bytes", cfr_dout, tmp);

      // commit ch0 held off by ch_idle for 10 cycles, then released
      step(1'b0, 1'b0, '0, '0, '0, 2'b01, 2'b00);
      for (int i = 0; i < 10; i++) begin
         idle(2'b00);
         check("hold_pend0", DW'(commit_pend[0]), DW'(1'b1));
         check("hold_active0", act_word(0, 0), init_word(0));
      end
      idle(2'b01);
      check("commit_done0", DW'(commit_done[0]), DW'(1'b1));
      check("copied_w0", act_word(0, 0), {MW{8'hA5}});
      check("ch1_untouched", act_word(1, 0), init_word(0));
      idle(2'b00);

      // shadow write on the copy edge: first commit gets old value, second the new
      step(1'b0, 1'b0, '0, '0, '0, 2'b10, 2'b00);
      step(1'b1, 1'b0, 12'h002, {MW{1'b1}}, {MW{8'h3C}}, 2'b00, 2'b10);
      check("race_old", act_word(1, 2), init_word(2));
      idle(2'b00);
      step(1'b0, 1'b0, '0, '0, '0, 2'b10, 2'b10);
      idle(2'b10);
      check("race_new", act_word(1, 2), {MW{8'h3C}});

      // status-register commit coincident with pin request: one copy only;
      // request during COPY re-enters PEND
      step(1'b1, 1'b0, 12'h200, 32'h1, DW'(2'b01), 2'b01, 2'b00);
      idle(2'b01);
      step(1'b0, 1'b0, '0, '0, '0, 2'b01, 2'b00);
      check("req_in_copy", DW'(commit_pend[0]), DW'(1'b1));
      step(1'b0, 1'b1, 12'h200, '0, '0, 2'b00, 2'b00);
      idle(2'b01);
      idle(2'b00);

      // illegal accesses
      step(1'b1, 1'b0, 12'h101, {MW{1'b1}}, {MW{8'h77}}, 2'b00, 2'b00);
      check("err_wr_active", DW'(cfr_err), DW'(1'b1));
      step(1'b0, 1'b1, 12'h3FF, '0, '0, 2'b00, 2'b00);
      check("err_rd_3ff", DW'(cfr_err), DW'(1'b1));
      check("err_rd_zero", cfr_dout, '0);
      idle(2'b00);
      check("err_cleared", DW'(cfr_err), DW'(1'b0));

      // reset while channel 1 pending
      step(1'b1, 1'b0, 12'h000, {MW{1'b1}}, {MW{8'h5A}}, 2'b10, 2'b00);
      check("pre_rst_pend1", DW'(commit_pend[1]), DW'(1'b1));
      apply_reset();
      check("rst_pend1", DW'(commit_pend[1]), DW'(1'b0));
      idle(2'b11);
      idle(2'b11);
      check("rst_no_done1", DW'(commit_done[1]), DW'(1'b0));
      check("rst_active_init", act_word(1, 0), init_word(0));

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 5))
            0, 1:    ra = AW'($urandom_range(0, NW-1));
            2:       ra = AW'(256 + $urandom_range(0, NC*NW-1));
            3:       ra = 12'h200;
            4:       ra = AW'($urandom_range(0, 4095));
            default: ra = ($urandom_range(0, 1) == 0) ? 12'h3FF : 12'h110;
         endcase
         for (int k = 0; k < DW/32; k++) rnd[k*32 +: 32] = $urandom();
         step(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), ra,
              ($urandom_range(0, 1) == 0) ? {MW{1'b1}} : MW'($urandom()),
              rnd,
              ($urandom_range(0, 7) == 0) ? NC'($urandom_range(0, 3)) : '0,
              NC'($urandom_range(0, 3)));
         if (i == 700) apply_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
